// File: rtl/layer_sequencer_if.sv
// Host/instruction-RAM/address-generator/MAC signal bundle for layer_sequencer.
// master = sequencer side, slave = surrounding datapath/host side.
interface layer_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int NK_W   = 8
);
  logic              start;
  logic [ADDR_W-1:0] num_layers;
  logic [ADDR_W-1:0] instr_addr;
  logic [NK_W-1:0]   instr_data;
  logic [NK_W-1:0]   nk;
  logic              ag_rst;
  logic              ag_read;
  logic              ag_finished;
  logic              neuron_finished;
  logic              ptr_load;
  logic              mac_rst;
  logic              mac_forget;
  logic              busy;
  logic              done;

  modport master (
    input  start, num_layers, instr_data, ag_finished, neuron_finished,
    output instr_addr, nk, ag_rst, ag_read, ptr_load, mac_rst, mac_forget, busy, done
  );

  modport slave (
    output start, num_layers, instr_data, ag_finished, neuron_finished,
    input  instr_addr, nk, ag_rst, ag_read, ptr_load, mac_rst, mac_forget, busy, done
  );
endinterface

// File: rtl/layer_sequencer.sv
// Walks the layer list in instruction RAM, driving address generator and MAC core
// per layer, and reports busy/done to the host.
module layer_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int NK_W     = 8,
  parameter int PIPE_LAT = 2
) (
  input logic              clk,
  input logic              reset,
  layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, RUN, DRAIN, NEXT, DONE
  } state_t;

  localparam int CW = $clog2(PIPE_LAT + 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] layer_idx;
  logic [ADDR_W-1:0] num_q;
  logic [NK_W-1:0]   nk_q;
  logic [CW-1:0]     drain_cnt;
  logic [PIPE_LAT-1:0] fsr, fsr_n;
  logic              last_layer;
  logic              drain_end;

  logic ag_rst_c, ag_read_c, ptr_load_c, mac_rst_c, done_c;

  // Extra bit so num_layers = 2^ADDR_W-1 terminates without wrapping.
  assign last_layer = ({1'b0, layer_idx} + (ADDR_W+1)'(1)) == {1'b0, num_q};
  assign drain_end  = drain_cnt == CW'(PIPE_LAT - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ag_rst_c   = 1'b0;
    ag_read_c  = 1'b0;
    ptr_load_c = 1'b0;
    mac_rst_c  = 1'b0;
    done_c     = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_n = (bus.num_layers == '0) ? DONE : FETCH;
      FETCH: state_n = LOAD;
      LOAD: begin
        ag_rst_c  = 1'b1;
        mac_rst_c = 1'b1;
        state_n   = (nk_q == '0) ? NEXT : RUN;
      end
      RUN: begin
        ag_read_c = 1'b1;
        if (bus.ag_finished) begin
          ptr_load_c = 1'b1;
          state_n    = DRAIN;
        end
      end
      DRAIN: if (drain_end) state_n = NEXT;
      NEXT:  state_n = last_layer ? DONE : FETCH;
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Forget pipe only accepts neuron_finished in RUN and keeps shifting through DRAIN.
  always_comb begin
    fsr_n = '0;
    if (state == RUN || state == DRAIN) begin
      fsr_n[0] = (state == RUN) && bus.neuron_finished;
      for (int unsigned i = 1; i < PIPE_LAT; i++) fsr_n[i] = fsr[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      layer_idx <= '0;
      num_q     <= '0;
      nk_q      <= '0;
      drain_cnt <= '0;
      fsr       <= '0;
    end else begin
      case (state)
        IDLE:  if (bus.start) num_q <= bus.num_layers;
        FETCH: nk_q <= bus.instr_data;
        NEXT:  if (!last_layer) layer_idx <= layer_idx + ADDR_W'(1);
        DONE:  layer_idx <= '0;
        default: ;
      endcase
      drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
      fsr       <= fsr_n;
    end
  end

  assign bus.instr_addr = layer_idx;
  assign bus.nk         = nk_q;
  assign bus.ag_rst     = ag_rst_c;
  assign bus.ag_read    = ag_read_c;
  assign bus.ptr_load   = ptr_load_c;
  assign bus.mac_rst    = mac_rst_c;
  assign bus.mac_forget = fsr[PIPE_LAT-1];
  assign bus.busy       = state != IDLE;
  assign bus.done       = done_c;

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: per-run expected timelines are built
// from the layer list, then compared against the DUT every cycle.
module tb_layer_sequencer;
  localparam int AW   = 8;
  localparam int NW   = 8;
  localparam int P    = 2;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  layer_sequencer_if #(.ADDR_W(AW), .NK_W(NW)) bus();
  layer_sequencer #(.ADDR_W(AW), .NK_W(NW), .PIPE_LAT(P)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  logic [NW-1:0] ram [256];
  assign bus.instr_data = ram[bus.instr_addr];

  // expected outputs per cycle of a run
  bit          e_busy [MAXC], e_done [MAXC], e_agrst [MAXC], e_read [MAXC];
  bit          e_ptr [MAXC], e_macrst [MAXC], e_fgt [MAXC];
  logic [7:0]  e_addr [MAXC], e_nk [MAXC];
  // stimulus per cycle
  bit          i_start [MAXC], i_agf [MAXC], i_nf [MAXC], i_rst [MAXC];
  logic [7:0]  i_nl [MAXC];

  int          run_len;
  logic [7:0]  m_nk;
  bit          quiet;

  int total = 0, bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int first_read, done_t, done_cnt, ptr_cnt, read_cnt;
  int fq[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic mark(input int t, input int l);
    e_busy[t] = 1'b1;
    e_addr[t] = 8'(l);
    e_nk[t]   = m_nk;
  endtask

  task automatic add_nf(input int t);
    i_nf[t]      = 1'b1;
    e_fgt[t + P] = 1'b1;
  endtask

  task automatic build(input int n);
    int t;
    int r;
    for (int i = 0; i < MAXC; i++) begin
      e_busy[i] = 0; e_done[i] = 0; e_agrst[i] = 0; e_read[i] = 0;
      e_ptr[i] = 0; e_macrst[i] = 0; e_fgt[i] = 0; e_addr[i] = '0; e_nk[i] = '0;
      i_start[i] = 0; i_agf[i] = 0; i_nf[i] = 0; i_rst[i] = 0;
      i_nl[i] = 8'($urandom_range(0, 255));
    end
    i_start[0] = 1'b1;
    i_nl[0]    = 8'(n);
    e_nk[0]    = m_nk;
    t = 1;
    for (int l = 0; l < n; l++) begin
      mark(t, l); m_nk = ram[l]; t++;                 // fetch
      mark(t, l); e_agrst[t] = 1; e_macrst[t] = 1; t++; // load
      if (m_nk != 0) begin
        r = 2 * int'(m_nk);
        for (int i = 0; i < r; i++) begin
          mark(t, l);
          e_read[t] = 1'b1;
          if (!quiet && $urandom_range(0, 3) == 0) add_nf(t);
          if (i == r - 1) begin
            i_agf[t] = 1'b1;
            e_ptr[t] = 1'b1;
          end
          t++;
        end
        for (int i = 0; i < P; i++) begin mark(t, l); t++; end
      end
      mark(t, l); t++;                                // next
    end
    mark(t, (n == 0) ? 0 : n - 1);
    e_done[t] = 1'b1;
    t++;
    for (int i = 0; i < 3; i++) begin e_nk[t] = m_nk; t++; end
    run_len = t;
    if (!quiet) begin
      for (int tt = 1; tt <= run_len - 4; tt++) begin
        if ($urandom_range(0, 4) == 0) i_start[tt] = 1'b1;
        if (!e_read[tt]) begin
          if ($urandom_range(0, 3) == 0) i_agf[tt] = 1'b1;
          if ($urandom_range(0, 3) == 0) i_nf[tt]  = 1'b1;
        end
      end
    end
  endtask

  task automatic apply_abort(input int at);
    for (int tt = at; tt < MAXC; tt++) begin
      i_start[tt] = 0; i_agf[tt] = 0; i_nf[tt] = 0;
      if (tt > at) begin
        e_busy[tt] = 0; e_done[tt] = 0; e_agrst[tt] = 0; e_read[tt] = 0;
        e_ptr[tt] = 0; e_macrst[tt] = 0; e_fgt[tt] = 0; e_addr[tt] = '0; e_nk[tt] = '0;
      end
    end
    for (int tt = at; tt < at + 3; tt++) i_rst[tt] = 1'b1;
    run_len = at + 6;
    m_nk    = '0;
  endtask

  task automatic run();
    first_read = -1; done_t = -1; done_cnt = 0; ptr_cnt = 0; read_cnt = 0;
    fq.delete();
    for (int t = 0; t < run_len; t++) begin
      @(posedge clk); #1;
      cyc                 = t;
      reset               = i_rst[t];
      bus.start           = i_start[t];
      bus.num_layers      = i_nl[t];
      bus.ag_finished     = i_agf[t];
      bus.neuron_finished = i_nf[t];
      chk_en              = 1'b1;
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    reset = 1'b0; bus.start = 1'b0; bus.ag_finished = 1'b0; bus.neuron_finished = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",       int'(bus.busy),       int'(e_busy[cyc]));
      chk("done",       int'(bus.done),       int'(e_done[cyc]));
      chk("ag_rst",     int'(bus.ag_rst),     int'(e_agrst[cyc]));
      chk("mac_rst",    int'(bus.mac_rst),    int'(e_macrst[cyc]));
      chk("ag_read",    int'(bus.ag_read),    int'(e_read[cyc]));
      chk("ptr_load",   int'(bus.ptr_load),   int'(e_ptr[cyc]));
      chk("mac_forget", int'(bus.mac_forget), int'(e_fgt[cyc]));
      chk("instr_addr", int'(bus.instr_addr), int'(e_addr[cyc]));
      chk("nk",         int'(bus.nk),         int'(e_nk[cyc]));
      if (bus.ag_read) begin
        read_cnt++;
        if (first_read < 0) first_read = cyc;
      end
      if (bus.done) begin done_cnt++; done_t = cyc; end
      if (bus.ptr_load) ptr_cnt++;
      if (bus.mac_forget) fq.push_back(cyc);
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.num_layers = '0;
    bus.ag_finished = 1'b0; bus.neuron_finished = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = '0;
    m_nk  = '0;
    quiet = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    int'(bus.busy),       0);
    chk("rst_done",    int'(bus.done),       0);
    chk("rst_ag_read", int'(bus.ag_read),    0);
    chk("rst_ag_rst",  int'(bus.ag_rst),     0);
    chk("rst_mac_rst", int'(bus.mac_rst),    0);
    chk("rst_ptr",     int'(bus.ptr_load),   0);
    chk("rst_forget",  int'(bus.mac_forget), 0);
    chk("rst_addr",    int'(bus.instr_addr), 0);
    chk("rst_nk",      int'(bus.nk),         0);
    reset = 1'b0;

    // zero layers
    build(0); run();
    chk("n0_done_t", done_t, 1);
    chk("n0_done_cnt", done_cnt, 1);
    chk("n0_reads", read_cnt, 0);

    // two layers, Nk = {3,2}
    ram[0] = 8'd3; ram[1] = 8'd2;
    build(2); run();
    chk("l2_first_read", first_read, 3);
    chk("l2_done_t", done_t, 21);
    chk("l2_ptr_cnt", ptr_cnt, 2);
    chk("l2_done_cnt", done_cnt, 1);

    // forget pipe timing, last forget in final drain cycle
    ram[0] = 8'd4;
    build(1); add_nf(6); add_nf(10); run();
    chk("fg_count", fq.size(), 2);
    if (fq.size() == 2) begin
      chk("fg_first", fq[0], 8);
      chk("fg_last", fq[1], 12);
    end
    chk("fg_done_t", done_t, 14);

    // empty middle layer
    ram[0] = 8'd2; ram[1] = 8'd0; ram[2] = 8'd1;
    build(3); run();
    chk("nk0_ptr_cnt", ptr_cnt, 2);
    chk("nk0_done_t", done_t, 20);

    // start pulses while busy
    ram[0] = 8'd3; ram[1] = 8'd2;
    build(2);
    i_start[5] = 1'b1; i_start[9] = 1'b1; i_start[15] = 1'b1; i_start[19] = 1'b1;
    run();
    chk("busy_start_done_t", done_t, 21);
    chk("busy_start_done_cnt", done_cnt, 1);
    chk("busy_start_ptr_cnt", ptr_cnt, 2);

    // reset mid-RUN
    ram[0] = 8'd3; ram[1] = 8'd3; ram[2] = 8'd3;
    build(3); apply_abort(5); run();
    chk("abort_done_cnt", done_cnt, 0);

    // randomized runs, some aborted
    quiet = 1'b0;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) ram[i] = 8'($urandom_range(0, 5));
      build(n);
      if ($urandom_range(0, 6) == 0) apply_abort($urandom_range(1, run_len - 5));
      run();
    end

    // maximum layer count
    for (int i = 0; i < 256; i++) ram[i] = ($urandom_range(0, 7) == 0) ? 8'd1 : 8'd0;
    build(255); run();
    chk("max_done_cnt", done_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
